// File: rtl/seq_lock_param.sv
// Serial combination lock: matches a valid-qualified bit stream MSB-first against a LEN-bit code.
// Define FAIL_LOCKOUT_EN to build the timed lockout after MAX_FAIL failed attempts.
module seq_lock_param #(
    parameter int unsigned       LEN         = 5,
    parameter logic [LEN-1:0]    RESET_CODE  = 5'b11001,
    parameter int unsigned       MAX_FAIL    = 3,
    parameter int unsigned       LOCKOUT_CYC = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          a_valid,
    input  logic                          a,
    input  logic                          code_we,
    input  logic [LEN-1:0]                code_in,
    output logic                          unlock,
    output logic                          locked_out,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
    output logic [$clog2(LEN)-1:0]        pos
);

    localparam int unsigned PW = $clog2(LEN);
    localparam int unsigned FW = $clog2(MAX_FAIL + 1);

    typedef enum logic [1:0] {
        StIdle,
        StMatch
`ifdef FAIL_LOCKOUT_EN
        , StLockout
`endif
    } state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  pos_q, pos_d;
    logic [FW-1:0]  fail_q, fail_d;
    logic [LEN-1:0] code_q, code_d;
    logic           exp_bit;
    logic           in_lockout;

    assign exp_bit = code_q[PW'(LEN - 1) - pos_q];

`ifdef FAIL_LOCKOUT_EN
    localparam int unsigned CW = $clog2(LOCKOUT_CYC + 1);
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          locked_q;

    assign in_lockout = (state_q == StLockout);
    assign locked_out = locked_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= (state_d == StLockout);
        end
    end
`else
    assign in_lockout = 1'b0;
    assign locked_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            pos_q   <= '0;
            fail_q  <= '0;
            code_q  <= RESET_CODE;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            fail_q  <= fail_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        fail_d  = fail_q;
        code_d  = code_q;
        unlock  = 1'b0;
`ifdef FAIL_LOCKOUT_EN
        lock_cnt_d = lock_cnt_q;
`endif
        if (in_lockout) begin
`ifdef FAIL_LOCKOUT_EN
            // Counter is loaded with LOCKOUT_CYC, so leaving at 1 gives exactly that many cycles.
            if (lock_cnt_q == CW'(1)) begin
                state_d    = StIdle;
                lock_cnt_d = '0;
                fail_d     = '0;
            end else begin
                lock_cnt_d = lock_cnt_q - CW'(1);
            end
`endif
        end else if (code_we) begin
            code_d  = code_in;
            pos_d   = '0;
            state_d = StIdle;
        end else if (a_valid) begin
            if (a == exp_bit) begin
                if (pos_q == PW'(LEN - 1)) begin
                    unlock  = 1'b1;
                    pos_d   = '0;
                    fail_d  = '0;
                    state_d = StIdle;
                end else begin
                    pos_d   = pos_q + PW'(1);
                    state_d = StMatch;
                end
            end else if (pos_q != '0) begin
                // Restart reusing the offending bit as a possible first code bit.
                pos_d   = (a == code_q[LEN-1]) ? PW'(1) : '0;
                state_d = (pos_d != '0) ? StMatch : StIdle;
`ifdef FAIL_LOCKOUT_EN
                fail_d = fail_q + FW'(1);
                if (fail_q == FW'(MAX_FAIL - 1)) begin
                    state_d    = StLockout;
                    lock_cnt_d = CW'(LOCKOUT_CYC);
                    pos_d      = '0;
                end
`else
                if (fail_q != FW'(MAX_FAIL)) begin
                    fail_d = fail_q + FW'(1);
                end
`endif
            end
        end
    end

    assign fail_cnt = fail_q;
    assign pos      = pos_q;

endmodule
